// File: rtl/slave_serial_mem_sp.sv
// Serial-bus memory slave: bit-serial address/data in, bit-serial read data out.
// Optional split-read path is built when SLAVE_SPLIT_EN is defined.
module slave_serial_mem_sp #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int READ_LAT     = 4,
  parameter int SPLIT_THRESH = 3
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              AD_SEL,
  input  logic              B_RW,
  input  logic              B_BUS_OUT,
  output logic              B_BUS_IN,
  output logic              B_ACK,
  output logic              B_SBSY,
  output logic              S_SPLIT,
  input  logic              B_SPLIT,
  input  logic              B_SPL_RESUME,
  output logic              S_DVALID,
  output logic [DATA_W-1:0] S_DOUT,
  output logic [3:0]        DBG_STATE
);

  // Bus handshake: a transaction starts when AD_SEL and B_BUS_OUT are both 1
  // in IDLE; the slave then samples one bit per cycle while AD_SEL stays high,
  // and any cycle with AD_SEL low (outside the split wait states) aborts it.
  localparam int MAX_AD  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int MAX_ALL = (MAX_AD > READ_LAT) ? MAX_AD : READ_LAT;
  localparam int CW      = $clog2(MAX_ALL + 1);
  localparam logic [CW-1:0] A_LAST = CW'(ADDR_W - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] R_LAST = CW'(READ_LAT - 1);
  localparam bit LONG_READ = (READ_LAT >= SPLIT_THRESH);

  typedef enum logic [3:0] {
    IDLE, ADDR, WDATA, WDONE, RWAIT, SPLREQ, SPLWAIT, SPLRDY, RDATA
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                mem_we;

  logic [DATA_W-1:0]   mem [2**ADDR_W];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      dout_q  <= dout_d;
    end
  end

  // Memory is deliberately not reset; contents survive RSTN.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[addr_q] <= wdata_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    dout_d  = dout_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (AD_SEL && B_BUS_OUT) begin
          rw_d    = B_RW;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (!AD_SEL) begin
          state_d = IDLE;
        end else begin
          addr_d = {B_BUS_OUT, addr_q[ADDR_W-1:1]};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == A_LAST) begin
            cnt_d = '0;
            if (rw_q) begin
              state_d = WDATA;
            end else begin
`ifdef SLAVE_SPLIT_EN
              state_d = LONG_READ ? SPLREQ : RWAIT;
`else
              state_d = RWAIT;
`endif
            end
          end
        end
      end
      WDATA: begin
        if (!AD_SEL) begin
          state_d = IDLE;
        end else begin
          wdata_d = {B_BUS_OUT, wdata_q[DATA_W-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == D_LAST) begin
            cnt_d   = '0;
            mem_we  = 1'b1;
            dout_d  = wdata_d;
            state_d = WDONE;
          end
        end
      end
      WDONE: state_d = IDLE;
      RWAIT: begin
        if (!AD_SEL) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == R_LAST) begin
            cnt_d   = '0;
            rdata_d = mem[addr_q];
            state_d = RDATA;
          end
        end
      end
`ifdef SLAVE_SPLIT_EN
      // An accepted split wins over a same-cycle deselect.
      SPLREQ: begin
        if (B_SPLIT) begin
          cnt_d   = '0;
          state_d = SPLWAIT;
        end else if (!AD_SEL) begin
          state_d = IDLE;
        end
      end
      SPLWAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == R_LAST) begin
          cnt_d   = '0;
          rdata_d = mem[addr_q];
          state_d = SPLRDY;
        end
      end
      SPLRDY: begin
        if (B_SPL_RESUME && AD_SEL) begin
          cnt_d   = '0;
          state_d = RDATA;
        end
      end
`endif
      RDATA: begin
        if (!AD_SEL) begin
          state_d = IDLE;
        end else begin
          rdata_d = {1'b0, rdata_q[DATA_W-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == D_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign B_SBSY    = (state_q != IDLE);
  assign B_ACK     = (state_q == WDONE) || (state_q == RDATA);
  assign S_DVALID  = (state_q == WDONE);
  assign B_BUS_IN  = (state_q == RDATA) ? rdata_q[0] : 1'b0;
  assign S_DOUT    = dout_q;
  assign DBG_STATE = state_q;

`ifdef SLAVE_SPLIT_EN
  assign S_SPLIT = (state_q == SPLREQ);
`else
  logic unused_split;
  assign unused_split = B_SPLIT ^ B_SPL_RESUME ^ LONG_READ;
  assign S_SPLIT = 1'b0;
`endif

endmodule

// File: tb/tb_slave_serial_mem_sp.sv
// Randomized bench for slave_serial_mem_sp: transaction-level model predicts
// every cycle's outputs; a few literal latency/data expectations pin the model.
module tb_slave_serial_mem_sp;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int RL = 4;
  localparam int ST = 3;
  localparam int EW = DW + 5;

  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  logic AD_SEL = 1'b0, B_RW = 1'b0, B_BUS_OUT = 1'b0;
  logic B_SPLIT = 1'b0, B_SPL_RESUME = 1'b0;
  logic B_BUS_IN, B_ACK, B_SBSY, S_SPLIT, S_DVALID;
  logic [DW-1:0] S_DOUT;
  logic [3:0] dbg_state;

  slave_serial_mem_sp #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .SPLIT_THRESH(ST)) dut (
    .CLK(CLK), .RSTN(RSTN), .AD_SEL(AD_SEL), .B_RW(B_RW), .B_BUS_OUT(B_BUS_OUT),
    .B_BUS_IN(B_BUS_IN), .B_ACK(B_ACK), .B_SBSY(B_SBSY), .S_SPLIT(S_SPLIT),
    .B_SPLIT(B_SPLIT), .B_SPL_RESUME(B_SPL_RESUME), .S_DVALID(S_DVALID),
    .S_DOUT(S_DOUT), .DBG_STATE(dbg_state)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int drv_n = 0;
  int start_n = 0;
  int last_wack = -1;
  int prev_wack = -1;
  int rcount = 0;
  logic [DW-1:0] rbits = '0;

  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] mdl [int];
  logic [AW-1:0] addr_list[$];
  logic [DW-1:0] mdl_dout = '0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [EW-1:0] mk(input logic ack, busy, bin, dv, spl);
    return {mdl_dout, spl, dv, bin, busy, ack};
  endfunction

  // One bus cycle: drive inputs just after the edge, queue the outputs it must show.
  task automatic cyc(input logic rn, ad, bo, rw, sp, rs, input logic [EW-1:0] e);
    @(posedge CLK);
    #1;
    RSTN = rn; AD_SEL = ad; B_BUS_OUT = bo; B_RW = rw; B_SPLIT = sp; B_SPL_RESUME = rs;
    drv_n++;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    logic ad;
    for (int i = 0; i < n; i++) begin
      ad = rb();
      cyc(1'b1, ad, ad ? 1'b0 : rb(), rb(), rb(), rb(), mk(0, 0, 0, 0, 0));
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // abort_k: bit index (address then data) where AD_SEL drops; rst_k: data bit where RSTN drops.
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input int abort_k, input int rst_k);
    logic b;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, rb(), rb(), mk(0, 0, 0, 0, 0));
    start_n = drv_n;
    for (int i = 0; i < AW + DW; i++) begin
      b = (i < AW) ? a[i] : d[i-AW];
      if (i == abort_k) begin
        cyc(1'b1, 1'b0, rb(), rb(), rb(), rb(), mk(0, 1, 0, 0, 0));
        return;
      end
      if (rst_k >= 0 && i == AW + rst_k) begin
        mdl_dout = '0;
        cyc(1'b0, 1'b1, b, rb(), rb(), rb(), mk(0, 0, 0, 0, 0));
        cyc(1'b0, 1'b1, rb(), rb(), rb(), rb(), mk(0, 0, 0, 0, 0));
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0));
        return;
      end
      cyc(1'b1, 1'b1, b, rb(), rb(), rb(), mk(0, 1, 0, 0, 0));
    end
    if (!mdl.exists(int'(a))) addr_list.push_back(a);
    mdl[int'(a)] = d;
    mdl_dout = d;
    cyc(1'b1, rb(), rb(), rb(), rb(), rb(), mk(1, 1, 0, 1, 0));
  endtask

  // abort_k < AW drops AD_SEL during address bit abort_k; >= AW during data bit abort_k-AW.
  task automatic rd(input logic [AW-1:0] a, input int abort_k, input bit split_abort);
    logic [DW-1:0] d;
    logic ad;
    d = mdl.exists(int'(a)) ? mdl[int'(a)] : '0;
    cyc(1'b1, 1'b1, 1'b1, 1'b0, rb(), rb(), mk(0, 0, 0, 0, 0));
    for (int i = 0; i < AW; i++) begin
      if (i == abort_k) begin
        cyc(1'b1, 1'b0, rb(), rb(), rb(), rb(), mk(0, 1, 0, 0, 0));
        return;
      end
      cyc(1'b1, 1'b1, a[i], rb(), rb(), rb(), mk(0, 1, 0, 0, 0));
    end
`ifdef SLAVE_SPLIT_EN
    if (RL >= ST) begin
      for (int i = 0; i < int'($urandom_range(0, 2)); i++)
        cyc(1'b1, 1'b1, rb(), rb(), 1'b0, rb(), mk(0, 1, 0, 0, 1));
      if (split_abort) begin
        cyc(1'b1, 1'b0, rb(), rb(), 1'b0, rb(), mk(0, 1, 0, 0, 1));
        return;
      end
      cyc(1'b1, 1'b1, rb(), rb(), 1'b1, rb(), mk(0, 1, 0, 0, 1));
      for (int i = 0; i < RL; i++)
        cyc(1'b1, rb(), rb(), rb(), rb(), rb(), mk(0, 1, 0, 0, 0));
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
        ad = rb();
        cyc(1'b1, ad, rb(), rb(), rb(), ad ? 1'b0 : rb(), mk(0, 1, 0, 0, 0));
      end
      cyc(1'b1, 1'b1, rb(), rb(), rb(), 1'b1, mk(0, 1, 0, 0, 0));
    end else begin
      for (int i = 0; i < RL; i++)
        cyc(1'b1, 1'b1, rb(), rb(), rb(), rb(), mk(0, 1, 0, 0, 0));
    end
`else
    if (split_abort) begin end
    for (int i = 0; i < RL; i++)
      cyc(1'b1, 1'b1, rb(), rb(), rb(), rb(), mk(0, 1, 0, 0, 0));
`endif
    for (int i = 0; i < DW; i++) begin
      if (i + AW == abort_k) begin
        cyc(1'b1, 1'b0, rb(), rb(), rb(), rb(), mk(1, 1, d[i], 0, 0));
        return;
      end
      cyc(1'b1, 1'b1, rb(), rb(), rb(), rb(), mk(1, 1, d[i], 0, 0));
    end
  endtask

  // Compare process: every driven cycle is checked at the falling edge.
  always @(negedge CLK) begin
    logic [EW-1:0] e, act;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {S_DOUT, S_SPLIT, S_DVALID, B_BUS_IN, B_SBSY, B_ACK};
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL outputs cycle=%0d got{dout,split,dv,bin,busy,ack}=%h exp=%h", drv_n, act, e);
      end
    end
  end

  always @(negedge CLK) begin
    if (B_ACK && S_DVALID) begin
      prev_wack = last_wack;
      last_wack = drv_n;
    end
    if (B_ACK && !S_DVALID) begin
      rbits = {B_BUS_IN, rbits[DW-1:1]};
      rcount++;
    end
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int op;
    repeat (3) cyc(1'b0, rb(), rb(), rb(), rb(), rb(), mk(0, 0, 0, 0, 0));
    idle(1);
    chk("rst_dbg_state", int'(dbg_state), 0);
    idle(2);

    wr(12'h0A5, 8'h3C, -1, -1);
    idle(2);
    chk("wr_ack_latency", last_wack - start_n, 21);
    chk("wr_sdout", int'(S_DOUT), 8'h3C);

    rcount = 0;
    rd(12'h0A5, -1, 1'b0);
    idle(2);
    chk("rd_ack_cycles", rcount, 8);
    chk("rd_data", int'(rbits), 8'h3C);

    wr(12'h7FF, 8'h5A, -1, -1);
    wr(12'h7FF, 8'hFF, 6, -1);
    idle(1);
    rcount = 0;
    rd(12'h7FF, -1, 1'b0);
    idle(2);
    chk("abort_keeps_data", int'(rbits), 8'h5A);

`ifdef SLAVE_SPLIT_EN
    rd(12'h0A5, -1, 1'b1);
    rcount = 0;
    rd(12'h0A5, -1, 1'b0);
    idle(2);
    chk("split_rd_data", int'(rbits), 8'h3C);
    chk("split_rd_cycles", rcount, 8);
`endif

    wr(12'h0A5, 8'h99, -1, 3);
    idle(1);
    rcount = 0;
    rd(12'h0A5, -1, 1'b0);
    idle(2);
    chk("reset_keeps_mem", int'(rbits), 8'h3C);
    wr(12'h0A5, 8'h77, -1, -1);
    rcount = 0;
    rd(12'h0A5, -1, 1'b0);
    idle(2);
    chk("post_reset_write", int'(rbits), 8'h77);

    wr(12'h001, 8'h11, -1, -1);
    wr(12'h002, 8'h22, -1, -1);
    idle(2);
    chk("b2b_ack_spacing", last_wack - prev_wack, 22);
    rcount = 0;
    rd(12'h001, -1, 1'b0);
    idle(1);
    chk("b2b_read1", int'(rbits), 8'h11);
    rd(12'h002, -1, 1'b0);
    idle(1);
    chk("b2b_read2", int'(rbits), 8'h22);

    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 5));
      a = AW'($urandom_range(0, 2**AW - 1));
      d = DW'($urandom_range(0, 2**DW - 1));
      case (op)
        0, 1: wr(a, d, -1, -1);
        2: wr(a, d, int'($urandom_range(0, AW + DW - 1)), -1);
        3, 4: rd(addr_list[$urandom_range(0, addr_list.size() - 1)], -1, ($urandom_range(0, 3) == 0));
        default: rd(addr_list[$urandom_range(0, addr_list.size() - 1)],
                    int'($urandom_range(0, AW + DW - 1)), 1'b0);
      endcase
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);
    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
